// File: rtl/ifetch.sv
// ifetch: instruction fetch stage. Holds the fetch PC, looks words up in a
// direct-mapped one-word-per-line instruction cache, fetches misses from the
// memory controller, and hands one instruction per cycle to the decoder.
// Optional cache: define IFETCH_ICACHE_EN to build the cache; without it
// every fetch goes to the memory controller.
module ifetch #(
  parameter int          ICACHE_IDX_W = 4,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        issue_stall,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  output logic        inst_done,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        drop;
  logic        buf_valid;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill;

  // A line is written whenever a memory word returns, even if it is dropped.
  assign fill = rdy && (state == WAIT_MEM) && mc_done;

`ifdef IFETCH_ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 30 - ICACHE_IDX_W;

  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [31:0]             data_mem [LINES];
  logic [ICACHE_IDX_W-1:0] rd_idx;
  logic [ICACHE_IDX_W-1:0] wr_idx;

  assign rd_idx = pc[ICACHE_IDX_W+1:2];
  assign wr_idx = mc_addr[ICACHE_IDX_W+1:2];

  // Lookup is combinational so a hit can be issued on the same edge it is seen.
  assign hit      = line_valid[rd_idx] && (tag_mem[rd_idx] == pc[31:ICACHE_IDX_W+2]);
  assign hit_data = data_mem[rd_idx];

  // Valid bits: cleared only by reset, never by rollback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: written on every memory return, no reset needed.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[wr_idx]  <= mc_addr[31:ICACHE_IDX_W+2];
      data_mem[wr_idx] <= mc_data;
    end
  end
`else
  logic cfg_unused;
  logic fill_unused;

  assign cfg_unused  = ICACHE_IDX_W[0];
  assign fill_unused = fill;
  assign hit         = 1'b0;
  assign hit_data    = 32'h0;
`endif

  // Fetch control: rollback > buffer drain > hit issue > miss request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      buf_valid <= 1'b0;
      buf_inst  <= 32'h0;
      buf_pc    <= 32'h0;
      mc_req    <= 1'b0;
      mc_addr   <= 32'h0;
      inst_done <= 1'b0;
      inst      <= 32'h0;
      inst_pc   <= 32'h0;
    end else if (rdy) begin
      inst_done <= 1'b0;
      if (rollback) begin
        pc        <= rollback_pc;
        buf_valid <= 1'b0;
        if (state == WAIT_MEM) begin
          if (mc_done) begin
            // Word returned with the redirect: fill happens, word discarded.
            mc_req <= 1'b0;
            drop   <= 1'b0;
            state  <= IDLE;
          end else begin
            // Request stays outstanding; its word must not be emitted.
            drop <= 1'b1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (buf_valid) begin
              if (!issue_stall) begin
                inst_done <= 1'b1;
                inst      <= buf_inst;
                inst_pc   <= buf_pc;
                buf_valid <= 1'b0;
                pc        <= buf_pc + 32'd4;
              end
            end else if (hit) begin
              if (!issue_stall) begin
                inst_done <= 1'b1;
                inst      <= hit_data;
                inst_pc   <= pc;
                pc        <= pc + 32'd4;
              end
            end else begin
              mc_req  <= 1'b1;
              mc_addr <= {pc[31:2], 2'b00};
              state   <= WAIT_MEM;
            end
          end
          WAIT_MEM: begin
            if (mc_done) begin
              mc_req <= 1'b0;
              state  <= IDLE;
              if (drop) begin
                drop <= 1'b0;
              end else if (!issue_stall) begin
                inst_done <= 1'b1;
                inst      <= mc_data;
                inst_pc   <= pc;
                pc        <= pc + 32'd4;
              end else begin
                // Decoder busy: park the word; pc advances when it drains.
                buf_valid <= 1'b1;
                buf_inst  <= mc_data;
                buf_pc    <= pc;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a fixed-latency memory model.
module tb_ifetch;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic [31:0] rollback_pc = 32'h0;
  logic        issue_stall = 1'b0;
  logic        mc_req;
  logic [31:0] mc_addr;
  logic        mc_done = 1'b0;
  logic [31:0] mc_data = 32'h0;
  logic        inst_done;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_assert = 0;
  int n_fail   = 0;
  int mem_cnt  = 0;

  always #5 clk = ~clk;

  ifetch #(.ICACHE_IDX_W(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .issue_stall(issue_stall), .mc_req(mc_req), .mc_addr(mc_addr), .mc_done(mc_done),
    .mc_data(mc_data), .inst_done(inst_done), .inst(inst), .inst_pc(inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Memory controller model: answers LAT edges after the request rises.
  always @(negedge clk) begin
    if (!rst || !mc_req) begin
      mem_cnt <= 0;
      mc_done <= 1'b0;
    end else if (rdy) begin
      mem_cnt <= mem_cnt + 1;
      mc_done <= (mem_cnt + 1 == LAT);
      mc_data <= mem_word(mc_addr);
    end
  end

  always @(negedge clk) begin
    if (rst && rdy && inst_done)
      $display("inst pc=%h inst=%h", inst_pc, inst);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!inst_done && n < 20);
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    int n;
    tick();
    chk("req", {31'h0, mc_req}, 32'h1);
    chk("req_addr", mc_addr, a);
    wait_inst(n);
    chk("inst_done", {31'h0, inst_done}, 32'h1);
    chk("inst_pc", inst_pc, a);
    chk("inst", inst, mem_word(a));
  endtask

  task automatic wait_req_low(output logic seen_inst);
    int n;
    n = 0;
    seen_inst = 1'b0;
    do begin
      tick();
      n++;
      seen_inst = seen_inst | inst_done;
    end while (mc_req && n < 20);
    chk("req_low", {31'h0, mc_req}, 32'h0);
  endtask

  initial begin
    int   n;
    logic seen;

    // Reset state
    repeat (3) tick();
    chk("rst_inst_done", {31'h0, inst_done}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mc_req", {31'h0, mc_req}, 32'h0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    rst = 1'b1;

    // Cold fetch
    tick();
    chk("cold_req", {31'h0, mc_req}, 32'h1);
    chk("cold_addr", mc_addr, 32'h0);
    wait_inst(n);
    chk("cold_latency", n, 32'd3);
    chk("cold_inst", inst, 32'h00000013);
    chk("cold_pc", inst_pc, 32'h0);
    tick();
    chk("cold_next_addr", mc_addr, 32'h4);
    wait_inst(n);
    chk("fetch4_inst", inst, 32'h00000413);
    expect_fetch(32'h8);
    expect_fetch(32'hC);

    // Rollback to 0: hits stream with the cache, misses without it
    rollback = 1'b1;
    rollback_pc = 32'h0;
    tick();
    rollback = 1'b0;
    chk("rb0_req", {31'h0, mc_req}, 32'h0);
    chk("rb0_done", {31'h0, inst_done}, 32'h0);
`ifdef IFETCH_ICACHE_EN
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hit_done", {31'h0, inst_done}, 32'h1);
      chk("hit_pc", inst_pc, 32'(i * 4));
      chk("hit_inst", inst, mem_word(32'(i * 4)));
      chk("hit_no_req", {31'h0, mc_req}, 32'h0);
    end
    expect_fetch(32'h10);
`else
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    expect_fetch(32'h8);
    expect_fetch(32'hC);
    expect_fetch(32'h10);
`endif
    expect_fetch(32'h14);
    expect_fetch(32'h18);
    expect_fetch(32'h1C);

    // Stall at data return for 0x20
    tick();
    chk("stall_addr", mc_addr, 32'h20);
    issue_stall = 1'b1;
    wait_req_low(seen);
    chk("stall_no_inst", {31'h0, seen}, 32'h0);
    tick();
    chk("stall_hold_done", {31'h0, inst_done}, 32'h0);
    chk("stall_hold_req", {31'h0, mc_req}, 32'h0);
    issue_stall = 1'b0;
    tick();
    chk("drain_done", {31'h0, inst_done}, 32'h1);
    chk("drain_pc", inst_pc, 32'h20);
    chk("drain_inst", inst, 32'h00002013);
    tick();
    chk("drain_next_req", {31'h0, mc_req}, 32'h1);
    chk("drain_next_addr", mc_addr, 32'h24);

    // Rollback while waiting on 0x24
    rollback = 1'b1;
    rollback_pc = 32'h100;
    tick();
    rollback = 1'b0;
    chk("rbw_req_held", {31'h0, mc_req}, 32'h1);
    chk("rbw_addr_held", mc_addr, 32'h24);
    wait_req_low(seen);
    chk("rbw_dropped", {31'h0, seen}, 32'h0);
    expect_fetch(32'h100);

    // Aliasing: 0x0 and 0x40 share a line
    rollback = 1'b1;
    rollback_pc = 32'h0;
    tick();
    rollback = 1'b0;
    expect_fetch(32'h0);
    rollback = 1'b1;
    rollback_pc = 32'h40;
    tick();
    rollback = 1'b0;
    expect_fetch(32'h40);
    rollback = 1'b1;
    rollback_pc = 32'h0;
    tick();
    rollback = 1'b0;
    tick();
    chk("alias_req", {31'h0, mc_req}, 32'h1);
    chk("alias_addr", mc_addr, 32'h0);

    // Rollback on the same edge as mc_done
    tick();
    tick();
    rollback = 1'b1;
    rollback_pc = 32'h200;
    tick();
    rollback = 1'b0;
    chk("rbd_req", {31'h0, mc_req}, 32'h0);
    chk("rbd_done", {31'h0, inst_done}, 32'h0);
    tick();
    chk("rbd_next_req", {31'h0, mc_req}, 32'h1);
    chk("rbd_next_addr", mc_addr, 32'h200);

    // Asynchronous reset in the middle of WAIT_MEM
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'h0, mc_req}, 32'h0);
    chk("arst_done", {31'h0, inst_done}, 32'h0);
    chk("arst_addr", mc_addr, 32'h0);
    tick();
    rst = 1'b1;
    expect_fetch(32'h0);

    // rdy=0 freezes everything, including the inst_done pulse
    rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("frz_req", {31'h0, mc_req}, 32'h0);
      chk("frz_done", {31'h0, inst_done}, 32'h1);
    end
    rdy = 1'b1;
    tick();
    chk("unfrz_req", {31'h0, mc_req}, 32'h1);
    chk("unfrz_addr", mc_addr, 32'h4);
    chk("unfrz_done", {31'h0, inst_done}, 32'h0);
    wait_inst(n);
    chk("unfrz_pc", inst_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
